// File: rtl/score_hp_tracker_pkg.sv
// scoreboard_pkg: shared FSM states, health default and BCD digit limit for the score/HP tracker
package scoreboard_pkg;
  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;
  localparam int HP_MAX_DEFAULT = 8;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  function automatic logic [3:0] clamp_digit(input logic [3:0] value);
    return value > DIGIT_MAX ? DIGIT_MAX : value;
  endfunction
endpackage

// File: rtl/score_hp_tracker_if.sv
// score_hp_tracker_if: score-add request handshake for both players
interface score_hp_tracker_if;
  logic       add_valid_1;
  logic       add_valid_2;
  logic [3:0] add_amt_1;
  logic [3:0] add_amt_2;
  logic       add_ready_1;
  logic       add_ready_2;
  modport master (output add_valid_1, add_valid_2, add_amt_1, add_amt_2, input add_ready_1, add_ready_2);
  modport slave (input add_valid_1, add_valid_2, add_amt_1, add_amt_2, output add_ready_1, add_ready_2);
endinterface

// File: rtl/score_hp_tracker_bcd_digit_add.sv
// bcd_digit_add: one BCD digit plus addend plus carry, producing a wrapped digit and carry out
module bcd_digit_add (
  input  logic [3:0] digit,
  input  logic [3:0] addend,
  input  logic       carry_in,
  output logic [3:0] sum_digit,
  output logic       carry_out
);
  logic [4:0] sum;
  // 5-bit binary sum, then fold back into decimal range
  always_comb begin
    sum = {1'b0, digit} + {1'b0, addend} + {4'd0, carry_in};
    carry_out = sum > 5'd9;
    sum_digit = carry_out ? 4'(sum - 5'd10) : sum[3:0];
  end
endmodule

// File: rtl/score_hp_tracker.sv
// score_hp_tracker: two-player BCD scores added one digit per cycle, plus half-heart damage counters
module score_hp_tracker
  import scoreboard_pkg::*;
#(
  parameter int HP_MAX = HP_MAX_DEFAULT
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                new_game,
  input  logic                dmg_1,
  input  logic                dmg_2,
  score_hp_tracker_if.slave   bus,
  output logic [3:0]          score0,
  output logic [3:0]          score1,
  output logic [3:0]          score2,
  output logic [3:0]          score3,
  output logic [3:0]          score0_2,
  output logic [3:0]          score1_2,
  output logic [3:0]          score2_2,
  output logic [3:0]          score3_2,
  output logic [3:0]          hp,
  output logic [3:0]          hp_2,
  output logic                dead_1,
  output logic                dead_2,
  output logic                game_over
);
  localparam logic [3:0] HP_TOP = 4'(HP_MAX);
  state_t      state;
  logic [1:0]  digit;
  logic [15:0] work;
  logic [15:0] score_p1;
  logic [15:0] score_p2;
  logic [3:0]  amt;
  logic        carry;
  logic        owner;
  logic [3:0]  cur_digit;
  logic [3:0]  addend;
  logic [3:0]  next_digit;
  logic        next_carry;
  logic        idle_ready;
  logic        accept_1;
  logic        accept_2;
  // status flags and handshake decode; everything is gated off while reset is held
  always_comb begin
    dead_1 = Reset_n && hp == HP_TOP;
    dead_2 = Reset_n && hp_2 == HP_TOP;
    game_over = dead_1 || dead_2;
    idle_ready = Reset_n && state == IDLE && !game_over;
    accept_1 = idle_ready && bus.add_valid_1;
    accept_2 = idle_ready && bus.add_valid_2 && !bus.add_valid_1;
    cur_digit = work[{digit, 2'b00} +: 4];
    addend = digit == 2'd0 ? amt : 4'd0;
  end
  assign bus.add_ready_1 = idle_ready;
  assign bus.add_ready_2 = idle_ready && !bus.add_valid_1;
  assign {score3, score2, score1, score0} = score_p1;
  assign {score3_2, score2_2, score1_2, score0_2} = score_p2;
  bcd_digit_add u_digit_add (
    .digit     (cur_digit),
    .addend    (addend),
    .carry_in  (carry),
    .sum_digit (next_digit),
    .carry_out (next_carry)
  );
  // add sequencer: latch request, ripple four digits through the shared adder, then commit
  always_ff @(posedge Clk) begin
    if (!Reset_n || new_game) begin
      state <= IDLE;
      digit <= 2'd0;
      work <= 16'd0;
      carry <= 1'b0;
      owner <= 1'b0;
      amt <= 4'd0;
      score_p1 <= 16'd0;
      score_p2 <= 16'd0;
    end else begin
      case (state)
        IDLE: if (accept_1 || accept_2) begin
          owner <= accept_2;
          amt <= clamp_digit(accept_1 ? bus.add_amt_1 : bus.add_amt_2);
          work <= accept_1 ? score_p1 : score_p2;
          carry <= 1'b0;
          digit <= 2'd0;
          state <= ADD;
        end
        ADD: begin
          work[{digit, 2'b00} +: 4] <= next_digit;
          carry <= next_carry;
          digit <= digit + 2'd1;
          state <= digit == 2'd3 ? COMMIT : ADD;
        end
        COMMIT: begin
          if (owner) score_p2 <= carry ? 16'h9999 : work;
          else score_p1 <= carry ? 16'h9999 : work;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // damage counters saturate at HP_MAX and freeze once either player is dead
  always_ff @(posedge Clk) begin
    if (!Reset_n || new_game) begin
      hp <= 4'd0;
      hp_2 <= 4'd0;
    end else begin
      if (dmg_1 && !game_over && hp < HP_TOP) hp <= hp + 4'd1;
      if (dmg_2 && !game_over && hp_2 < HP_TOP) hp_2 <= hp_2 + 4'd1;
    end
  end
endmodule

// File: tb/tb_score_hp_tracker.sv
// tb_score_hp_tracker: scoreboard bench with a decimal reference model for scores and health
module tb_score_hp_tracker;
  localparam int HP = 8;
  localparam int S_P1 = 0, S_P2 = 1, S_HP1 = 2, S_HP2 = 3, S_RDY1 = 4, S_RDY2 = 5, S_DEAD1 = 6, S_DEAD2 = 7, S_GO = 8;
  typedef struct {
    int    cyc;
    int    sel;
    int    exp;
    string name;
  } chk_t;
  logic Clk, Reset_n, new_game, dmg_1, dmg_2;
  logic [3:0] score0, score1, score2, score3, score0_2, score1_2, score2_2, score3_2, hp, hp_2;
  logic dead_1, dead_2, game_over;
  score_hp_tracker_if bus ();
  score_hp_tracker #(.HP_MAX(HP)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .new_game(new_game), .dmg_1(dmg_1), .dmg_2(dmg_2), .bus(bus),
    .score0(score0), .score1(score1), .score2(score2), .score3(score3),
    .score0_2(score0_2), .score1_2(score1_2), .score2_2(score2_2), .score3_2(score3_2),
    .hp(hp), .hp_2(hp_2), .dead_1(dead_1), .dead_2(dead_2), .game_over(game_over)
  );
  chk_t sb[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int m1, m2, h1, h2;
  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end
  always @(posedge Clk) cyc <= cyc + 1;
  function automatic int bcd(input int v);
    return (v / 1000 % 10) * 4096 + (v / 100 % 10) * 256 + (v / 10 % 10) * 16 + v % 10;
  endfunction
  function automatic int dut_val(input int sel);
    case (sel)
      S_P1: return int'({score3, score2, score1, score0});
      S_P2: return int'({score3_2, score2_2, score1_2, score0_2});
      S_HP1: return int'(hp);
      S_HP2: return int'(hp_2);
      S_RDY1: return int'(bus.add_ready_1);
      S_RDY2: return int'(bus.add_ready_2);
      S_DEAD1: return int'(dead_1);
      S_DEAD2: return int'(dead_2);
      S_GO: return int'(game_over);
      default: return -1;
    endcase
  endfunction
  task automatic expect_at(input int at, input int sel, input int val, input string nm);
    chk_t c;
    c.cyc = at;
    c.sel = sel;
    c.exp = val;
    c.name = nm;
    sb.push_back(c);
  endtask
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask
  always @(negedge Clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc || dut_val(sb[i].sel) != sb[i].exp) begin
          failures++;
          $display("FAIL %s cycle %0d: got %0h expected %0h", sb[i].name, sb[i].cyc, dut_val(sb[i].sel), sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end
  task automatic status_expect(input int at);
    expect_at(at, S_HP1, h1, "hp");
    expect_at(at, S_HP2, h2, "hp_2");
    expect_at(at, S_DEAD1, int'(h1 == HP), "dead_1");
    expect_at(at, S_DEAD2, int'(h2 == HP), "dead_2");
    expect_at(at, S_GO, int'(h1 == HP || h2 == HP), "game_over");
  endtask
  task automatic new_game_pulse(input bit with_dmg);
    new_game = 1;
    dmg_1 = with_dmg;
    m1 = 0; m2 = 0; h1 = 0; h2 = 0;
    expect_at(cyc + 1, S_P1, 0, "newgame_p1");
    expect_at(cyc + 1, S_P2, 0, "newgame_p2");
    expect_at(cyc + 1, S_RDY1, 1, "newgame_ready");
    status_expect(cyc + 1);
    tick();
    new_game = 0;
    dmg_1 = 0;
  endtask
  task automatic hit(input int p);
    bit over;
    over = h1 == HP || h2 == HP;
    if (p == 1) dmg_1 = 1; else dmg_2 = 1;
    if (!over && p == 1 && h1 < HP) h1++;
    if (!over && p == 2 && h2 < HP) h2++;
    status_expect(cyc + 1);
    tick();
    dmg_1 = 0;
    dmg_2 = 0;
  endtask
  task automatic do_add(input int p, input int amt, input bit rnd_dmg);
    int c, a, old, nw;
    c = cyc;
    a = amt > 9 ? 9 : amt;
    old = p == 1 ? m1 : m2;
    nw = old + a > 9999 ? 9999 : old + a;
    expect_at(c + 5, p == 1 ? S_P1 : S_P2, bcd(old), "score_hold");
    expect_at(c + 6, p == 1 ? S_P1 : S_P2, bcd(nw), "score_commit");
    for (int k = 1; k <= 5; k++) begin
      expect_at(c + k, S_RDY1, 0, "ready1_busy");
      expect_at(c + k, S_RDY2, 0, "ready2_busy");
    end
    expect_at(c + 6, S_RDY1, 1, "ready1_idle");
    expect_at(c + 6, S_RDY2, 1, "ready2_idle");
    if (p == 1) begin bus.add_valid_1 = 1; bus.add_amt_1 = 4'(amt); end
    else begin bus.add_valid_2 = 1; bus.add_amt_2 = 4'(amt); end
    for (int k = 0; k < 6; k++) begin
      if (rnd_dmg && h2 < HP - 1 && $urandom_range(3) == 0) begin
        dmg_2 = 1;
        h2++;
        expect_at(cyc + 1, S_HP2, h2, "hp2_during_add");
      end
      tick();
      bus.add_valid_1 = 0;
      bus.add_valid_2 = 0;
      dmg_2 = 0;
    end
    if (p == 1) m1 = nw; else m2 = nw;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int c;
    Reset_n = 0; new_game = 0; dmg_1 = 0; dmg_2 = 0;
    bus.add_valid_1 = 0; bus.add_valid_2 = 0; bus.add_amt_1 = 0; bus.add_amt_2 = 0;
    m1 = 0; m2 = 0; h1 = 0; h2 = 0;
    @(negedge Clk);
    #1;
    expect_at(cyc + 1, S_RDY1, 0, "reset_ready1");
    expect_at(cyc + 1, S_RDY2, 0, "reset_ready2");
    expect_at(cyc + 1, S_P1, 0, "reset_p1");
    expect_at(cyc + 1, S_P2, 0, "reset_p2");
    status_expect(cyc + 1);
    tick();
    tick();
    Reset_n = 1;
    expect_at(cyc + 1, S_RDY1, 1, "release_ready1");
    expect_at(cyc + 1, S_RDY2, 1, "release_ready2");
    tick();
    do_add(1, 7, 0);
    new_game_pulse(0);
    c = cyc;
    bus.add_valid_1 = 1; bus.add_amt_1 = 4'd3;
    bus.add_valid_2 = 1; bus.add_amt_2 = 4'd4;
    for (int k = 1; k <= 5; k++) expect_at(c + k, S_RDY2, 0, "both_p2_wait");
    expect_at(c + 5, S_P1, 0, "both_p1_hold");
    expect_at(c + 6, S_P1, bcd(3), "both_p1_commit");
    expect_at(c + 6, S_RDY2, 1, "both_p2_ready");
    for (int k = 7; k <= 11; k++) expect_at(c + k, S_RDY1, 0, "both_p2_busy");
    expect_at(c + 11, S_P2, 0, "both_p2_hold");
    expect_at(c + 12, S_P2, bcd(4), "both_p2_commit");
    tick();
    bus.add_valid_1 = 0;
    for (int k = 0; k < 6; k++) tick();
    bus.add_valid_2 = 0;
    for (int k = 0; k < 5; k++) tick();
    m1 = 3; m2 = 4;
    new_game_pulse(0);
    for (int n = 0; n < 40; n++) do_add(int'($urandom_range(1, 2)), int'($urandom_range(1, 15)), 1);
    new_game_pulse(0);
    for (int n = 0; n < 111; n++) do_add(1, $urandom_range(1) == 0 ? 9 : 12, 0);
    do_add(1, 5, 0);
    for (int n = 0; n < 999; n++) do_add(1, 9, 0);
    do_add(1, 3, 0);
    do_add(1, 9, 0);
    do_add(1, 15, 0);
    hit(1);
    hit(1);
    do_add(1, 3, 0);
    c = cyc;
    bus.add_valid_1 = 1; bus.add_amt_1 = 4'd5;
    tick();
    bus.add_valid_1 = 0;
    tick();
    new_game_pulse(1);
    expect_at(c + 6, S_P1, 0, "abort_no_commit");
    expect_at(c + 7, S_P1, 0, "abort_no_commit_late");
    for (int k = 0; k < 5; k++) tick();
    c = cyc;
    bus.add_valid_1 = 1; bus.add_amt_1 = 4'd6;
    tick();
    bus.add_valid_1 = 0;
    tick();
    tick();
    Reset_n = 0;
    expect_at(c + 4, S_RDY1, 0, "inreset_ready1");
    expect_at(c + 4, S_GO, 0, "inreset_game_over");
    tick();
    Reset_n = 1;
    expect_at(c + 5, S_RDY1, 1, "postreset_ready1");
    expect_at(c + 7, S_P1, 0, "reset_no_commit");
    expect_at(c + 10, S_P1, 0, "reset_no_commit_late");
    for (int k = 0; k < 6; k++) tick();
    for (int n = 0; n < 9; n++) hit(1);
    hit(2);
    checks++;
    if (dead_1 !== 1'b1) begin failures++; $display("FAIL direct_dead_1: got %0b", dead_1); end
    checks++;
    if (game_over !== 1'b1) begin failures++; $display("FAIL direct_game_over: got %0b", game_over); end
    checks++;
    if (hp_2 !== 4'd0) begin failures++; $display("FAIL direct_hp_2: got %0h", hp_2); end
    c = cyc;
    bus.add_valid_1 = 1; bus.add_amt_1 = 4'd4;
    for (int k = 1; k <= 6; k++) begin
      expect_at(c + k, S_RDY1, 0, "dead_ready1");
      expect_at(c + k, S_P1, 0, "dead_no_add");
    end
    for (int k = 0; k < 6; k++) tick();
    bus.add_valid_1 = 0;
    new_game_pulse(0);
    tick();
    tick();
    checks++;
    if ({score3, score2, score1, score0} !== 16'd0) begin failures++; $display("FAIL direct_final_p1: got %0h", {score3, score2, score1, score0}); end
    checks++;
    if (hp !== 4'd0) begin failures++; $display("FAIL direct_final_hp: got %0h", hp); end
    checks++;
    if (bus.add_ready_1 !== 1'b1) begin failures++; $display("FAIL direct_final_ready1: got %0b", bus.add_ready_1); end
    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("FAIL %s cycle %0d: never compared", sb[i].name, sb[i].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
